dmem_req_ctrl: RTL
==================

Name: dmem_req_ctrl

Overview:
MEM-stage request controller sitting directly upstream of the data-memory top (store/load units plus BRAM). It accepts one load/store request per handshake from the EX/MEM pipeline register. It checks alignment and range, then drives the data-memory port with address and func3 held stable across the synchronous BRAM read. It returns a response (load data or fault flags) and asserts stall to the pipeline while busy.

Parameters:
XLEN, 64, data/address width
DMEM_BYTES, 65536, addressable bytes (8192 doublewords); addr >= DMEM_BYTES is out of range

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present from EX/MEM
req_ready  out  1  controller can accept
req_we  in  1  store request
req_re  in  1  load request
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data (unshifted rs2)
req_func3  in  3  RISC-V load/store func3
stall  out  1  req_valid & ~req_ready
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  load result (0 unless load completes)
resp_misalign  out  1  misaligned fault, valid with resp_valid
resp_oob  out  1  out-of-range fault, valid with resp_valid
dm_we  out  1  to data memory write enable
dm_re  out  1  to data memory read enable
dm_addr  out  XLEN  to data memory address
dm_data  out  XLEN  to data memory store data
dm_func3  out  3  to data memory func3
dm_rdata  in  XLEN  from data memory extended load data

Behaviour:
- Interface (decided): single clock clk; reset rst_n is synchronous and active-low.
- States: IDLE, ISSUE_R, ISSUE_W, RESP_R, FAULT.
- req_ready = (state==IDLE). Accept = req_valid & req_ready. On accept, register addr, wdata, func3, we, re.
- Precedence: req_we=1 means store, even if req_re=1. req_re only means load. Neither set means nop: go to FAULT with both fault flags 0; resp_valid pulses next cycle with no memory access.
- Alignment by func3[1:0]: 00 always aligned; 01 needs addr[0]=0; 10 needs addr[1:0]=00; 11 needs addr[2:0]=000.
- Range: fault when addr >= DMEM_BYTES.
- Fault on accept goes to FAULT. Misalign has priority in reporting, but both flags may be set. No dm_we/dm_re is ever asserted for a faulted request.
- Store accepted in cycle N goes to ISSUE_W in N+1: dm_we=1, resp_valid=1. Then returns to IDLE.
- Load accepted in cycle N goes to ISSUE_R in N+1: dm_re=1, BRAM samples at end of N+1. RESP_R in N+2: dm_re=1, resp_valid=1, resp_rdata=dm_rdata. Then returns to IDLE.
- FAULT: resp_valid=1, flags registered, then returns to IDLE.
- dm_addr, dm_func3 and dm_data come from the request registers and stay constant from ISSUE through RESP. This is required because load extraction uses addr[2:0] and func3 combinationally in the response cycle.
- dm_we = (state==ISSUE_W) & rst_n. No write occurs in any cycle with reset asserted.
- Reset: state IDLE, all request registers 0. All outputs 0 except req_ready=1 after release; req_ready=0 while rst_n=0.
- Reset mid-load abandons the request with no response. Reset in the ISSUE_W cycle suppresses the write.
- Throughput: back-to-back requests cost 2 cycles per store/fault and 3 cycles per load. Inputs are ignored while req_ready=0.

Optional Feature:
DMEM_OUTREG_EN: when defined, adds state RD_WAIT between ISSUE_R and RESP_R to match a BRAM with its output register enabled. Load response then arrives at N+3, dm_re stays high through RD_WAIT, and address/func3 stay held. When undefined, load response is at N+2 as above. Stores and faults are unchanged in both cases.

Decomposition:
- Shared package dmem_pkg: func3 encodings (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD), size field decode, state enum, DMEM_BYTES default.
- One sub-module dmem_align_chk: combinational addr + func3 → misalign, oob.

Test Plan:
- Store then load: SD 0xDEADBEEF_CAFEF00D @0x10 then LD @0x10. Store resp_valid at N+1. Load resp_rdata=0xDEADBEEFCAFEF00D at N+2 (N+3 with macro).
- Sub-word load: LB @0x17 after that SD gives 0xFFFF_FFFF_FFFF_FFDE. LBU @0x17 gives 0xDE. dm_addr/dm_func3 are stable across ISSUE_R and RESP_R.
- Misalign: LW @0x12 gives resp_valid at N+1 with resp_misalign=1, resp_rdata=0, dm_we/dm_re=0 throughout. SH @0x13 behaves the same.
- Out of range: SD @0x10000 gives resp_oob=1 and no write; a follow-up LD @0x0 returns the prior contents.
- Reset mid-op: assert rst_n=0 during ISSUE_W of SW @0x20. A later LW @0x20 returns the old value, and there is no resp_valid for the aborted request.
- Stall/backpressure: hold req_valid with 3 back-to-back loads. stall=1 in the non-IDLE cycles. Exactly 3 resp_valid pulses arrive, 3 cycles apart.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the MEM-stage data-memory request controller.
//   - RISC-V load/store func3 encodings
//   - access-size alignment mask helper
//   - controller state enum (RD_WAIT exists only with DMEM_OUTREG_EN defined)
//   - default XLEN / DMEM_BYTES
package dmem_pkg;

  localparam int          XLEN_DEF       = 64;
  localparam int unsigned DMEM_BYTES_DEF = 65536;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_R,
    ISSUE_W,
    RESP_R,
    FAULT
`ifdef DMEM_OUTREG_EN
    , RD_WAIT
`endif
  } state_e;

  // Low address bits that must be zero for an access of size func3[1:0].
  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 3'b000;
      2'b01:   size_mask = 3'b001;
      2'b10:   size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// dmem_req_ctrl_if: request/response handshake between the EX/MEM pipeline
// register (master) and dmem_req_ctrl (slave).
//   req_valid/req_ready, req_we, req_re, req_addr, req_wdata, req_func3
//   stall, resp_valid, resp_rdata, resp_misalign, resp_oob
interface dmem_req_ctrl_if import dmem_pkg::*; #(parameter int XLEN = XLEN_DEF);
  logic            req_valid, req_ready, req_we, req_re;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic [2:0]      req_func3;
  logic            stall, resp_valid, resp_misalign, resp_oob;
  logic [XLEN-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_re, req_addr, req_wdata, req_func3,
    input  req_ready, stall, resp_valid, resp_rdata, resp_misalign, resp_oob
  );
  modport slave (
    input  req_valid, req_we, req_re, req_addr, req_wdata, req_func3,
    output req_ready, stall, resp_valid, resp_rdata, resp_misalign, resp_oob
  );
endinterface

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: combinational access checker.
//   i_addr     byte address
//   i_size     func3[1:0] access size
//   o_misalign address not naturally aligned for the size
//   o_oob      address >= DMEM_BYTES
module dmem_align_chk import dmem_pkg::*; #(
  parameter int          XLEN       = XLEN_DEF,
  parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEF
) (
  input  logic [XLEN-1:0] i_addr,
  input  logic [1:0]      i_size,
  output logic            o_misalign,
  output logic            o_oob
);
  assign o_misalign = |(i_addr[2:0] & size_mask(i_size));
  assign o_oob      = (i_addr >= XLEN'(DMEM_BYTES));
endmodule

// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: MEM-stage request controller in front of the data memory.
// Accepts one load/store per handshake, checks alignment/range, drives the
// memory port with address/func3 held from issue through response, and
// returns a one-cycle response pulse (load data or fault flags).
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   bus (slave)      request/response handshake, see dmem_req_ctrl_if
//   o_dm_we/o_dm_re  data-memory write/read enable
//   o_dm_addr/o_dm_data/o_dm_func3  held request fields
//   i_dm_rdata       extended load data from the data memory
// Build option: DMEM_OUTREG_EN adds RD_WAIT for a BRAM with output register.
module dmem_req_ctrl import dmem_pkg::*; #(
  parameter int          XLEN       = XLEN_DEF,
  parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  dmem_req_ctrl_if.slave  bus,
  output logic            o_dm_we,
  output logic            o_dm_re,
  output logic [XLEN-1:0] o_dm_addr,
  output logic [XLEN-1:0] o_dm_data,
  output logic [2:0]      o_dm_func3,
  input  logic [XLEN-1:0] i_dm_rdata
);
  state_e          r_state, w_next;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic [2:0]      r_func3;
  logic            r_mis, r_oob;
  logic            w_mis, w_oob, w_access, w_acc;
  logic            w_ready, w_we, w_re, w_rvalid, w_req_ready;

  dmem_align_chk #(.XLEN(XLEN), .DMEM_BYTES(DMEM_BYTES)) u_chk (
    .i_addr     (bus.req_addr),
    .i_size     (bus.req_func3[1:0]),
    .o_misalign (w_mis),
    .o_oob      (w_oob)
  );

  assign w_access = bus.req_we | bus.req_re;
  assign w_acc    = bus.req_valid & w_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Direction is carried by the state (ISSUE_W vs ISSUE_R), so only the
  // payload and fault flags are latched here.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_func3 <= '0;
      r_mis   <= 1'b0;
      r_oob   <= 1'b0;
    end else if (w_acc) begin
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_func3 <= bus.req_func3;
      // A nop reports through FAULT with both flags clear.
      r_mis   <= w_mis & w_access;
      r_oob   <= w_oob & w_access;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_we     = 1'b0;
    w_re     = 1'b0;
    w_rvalid = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          if (!w_access || w_mis || w_oob) w_next = FAULT;
          else if (bus.req_we)             w_next = ISSUE_W;  // store wins over load
          else                             w_next = ISSUE_R;
        end
      end
      ISSUE_W: begin
        w_we     = 1'b1;
        w_rvalid = 1'b1;
        w_next   = IDLE;
      end
      ISSUE_R: begin
        w_re = 1'b1;
`ifdef DMEM_OUTREG_EN
        w_next = RD_WAIT;
`else
        w_next = RESP_R;
`endif
      end
`ifdef DMEM_OUTREG_EN
      RD_WAIT: begin
        w_re   = 1'b1;
        w_next = RESP_R;
      end
`endif
      RESP_R: begin
        w_re     = 1'b1;
        w_rvalid = 1'b1;
        w_next   = IDLE;
      end
      FAULT: begin
        w_rvalid = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Everything visible is squashed while reset is held, so a reset landing in
  // ISSUE_W or RESP_R neither writes nor reports.
  assign w_req_ready       = w_ready & i_rst_n;
  assign bus.req_ready     = w_req_ready;
  assign bus.stall         = bus.req_valid & ~w_req_ready;
  assign bus.resp_valid    = w_rvalid & i_rst_n;
  assign bus.resp_rdata    = (r_state == RESP_R && i_rst_n) ? i_dm_rdata : '0;
  assign bus.resp_misalign = (r_state == FAULT) & r_mis & i_rst_n;
  assign bus.resp_oob      = (r_state == FAULT) & r_oob & i_rst_n;

  assign o_dm_we    = w_we & i_rst_n;
  assign o_dm_re    = w_re & i_rst_n;
  assign o_dm_addr  = r_addr;
  assign o_dm_data  = r_wdata;
  assign o_dm_func3 = r_func3;
endmodule
